// File: rtl/seg7_pkg.sv
// Shared segment patterns, code points and width helper for the 7-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned seg7_cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit code to logical (active-high) a..g pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (code_i)
      4'd0:       seg_c = SEG_0;
      4'd1:       seg_c = SEG_1;
      4'd2:       seg_c = SEG_2;
      4'd3:       seg_c = SEG_3;
      4'd4:       seg_c = SEG_4;
      4'd5:       seg_c = SEG_5;
      4'd6:       seg_c = SEG_6;
      4'd7:       seg_c = SEG_7;
      4'd8:       seg_c = SEG_8;
      4'd9:       seg_c = SEG_9;
      CODE_MINUS: seg_c = SEG_MINUS;
      default:    seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver with leading-zero blanking,
// a dark guard cycle at each slot start and registered, polarity-adjusted pins.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          LZ_BLANK       = 1'b1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [N_DIGITS-1:0]   dot_in,
  input  logic                  load,
  output logic [6:0]            display,
  output logic                  ponto,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  frame_done
);

  localparam int unsigned PW = seg7_cnt_width(REFRESH_DIV);
  localparam int unsigned IW = seg7_cnt_width(N_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
  logic [N_DIGITS-1:0]   dot_q, dot_d;
  logic                  frame_q, frame_d;
  logic [6:0]            disp_q, disp_d;
  logic                  ponto_q, ponto_d;
  logic [N_DIGITS-1:0]   anode_q, anode_d;

  logic [N_DIGITS-1:0]   blank_c;
  logic                  lead_c;
  logic [3:0]            cur_code_c;
  logic                  cur_dot_c;
  logic                  cur_blank_c;
  logic [N_DIGITS-1:0]   anode_log_c;
  logic [6:0]            seg_c;

  // Zero digits stay blank while every more-significant digit is blank; digit 0 always shows.
  always_comb begin
    blank_c = '0;
    lead_c  = LZ_BLANK;
    for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
      if (lead_c && (bcd_q[4*i +: 4] == 4'd0)) begin
        blank_c[i] = 1'b1;
      end else begin
        lead_c = 1'b0;
      end
    end
  end

  always_comb begin
    cur_code_c  = '0;
    cur_dot_c   = 1'b0;
    cur_blank_c = 1'b0;
    anode_log_c = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        cur_code_c  = bcd_q[4*i +: 4];
        cur_dot_c   = dot_q[i];
        cur_blank_c = blank_c[i];
        anode_log_c[i] = (presc_q != '0);
      end
    end
  end

  seg7_decode u_decode (
    .code_i (cur_blank_c ? CODE_BLANK : cur_code_c),
    .seg_c  (seg_c)
  );

  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    frame_d = (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);
    bcd_d   = load ? bcd_in : bcd_q;
    dot_d   = load ? dot_in : dot_q;
    disp_d  = {7{SEG_ACTIVE_LOW}} ^ seg_c;
    ponto_d = SEG_ACTIVE_LOW ^ cur_dot_c;
    anode_d = {N_DIGITS{AN_ACTIVE_LOW}} ^ anode_log_c;
  end

  // Reset drives every pin to its inactive level for the chosen polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      bcd_q   <= '0;
      dot_q   <= '0;
      frame_q <= 1'b0;
      disp_q  <= {7{SEG_ACTIVE_LOW}};
      ponto_q <= SEG_ACTIVE_LOW;
      anode_q <= {N_DIGITS{AN_ACTIVE_LOW}};
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      dot_q   <= dot_d;
      frame_q <= frame_d;
      disp_q  <= disp_d;
      ponto_q <= ponto_d;
      anode_q <= anode_d;
    end
  end

  assign display    = disp_q;
  assign ponto      = ponto_q;
  assign anode      = anode_q;
  assign frame_done = frame_q;

endmodule
